// File: rtl/keynsham_mem_arbiter_pkg.sv
// Shared types and constants for the Keynsham memory arbiter.
//   state_e   : arbiter FSM state encodings (2-bit)
//   grant_e   : which requester owns (or last owned) the memory port
//   mem_ctl_t : non-address fields of the request presented on the memory port
package keynsham_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 30;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BSEL_W     = 4;

  localparam logic [BSEL_W-1:0] BSEL_ALL = 4'hf;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  typedef struct packed {
    logic [BSEL_W-1:0] bytesel;
    logic              wr_en;
    logic [DATA_W-1:0] wr_val;
  } mem_ctl_t;

endpackage

// File: rtl/keynsham_mem_arbiter_if.sv
// Bundle of the instruction bus, data bus and memory port seen by the arbiter.
//   slave  : arbiter view (requests in, acks/data out, memory request out)
//   master : environment view (requesters and memory model)
interface keynsham_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 30
);
  import keynsham_mem_arbiter_pkg::*;

  // instruction bus
  logic                  i_access;
  logic                  i_cs;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_W-1:0]     i_data;
  logic                  i_ack;
  // data bus
  logic                  d_access;
  logic                  d_cs;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [BSEL_W-1:0]     d_bytesel;
  logic                  d_wr_en;
  logic [DATA_W-1:0]     d_wr_val;
  logic [DATA_W-1:0]     d_data;
  logic                  d_ack;
  // memory port
  logic                  m_access;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [BSEL_W-1:0]     m_bytesel;
  logic                  m_wr_en;
  logic [DATA_W-1:0]     m_wr_val;
  logic [DATA_W-1:0]     m_data;
  logic                  m_ack;

  modport slave (
    input  i_access, i_cs, i_addr,
    output i_data, i_ack,
    input  d_access, d_cs, d_addr, d_bytesel, d_wr_en, d_wr_val,
    output d_data, d_ack,
    output m_access, m_addr, m_bytesel, m_wr_en, m_wr_val,
    input  m_data, m_ack
  );

  modport master (
    output i_access, i_cs, i_addr,
    input  i_data, i_ack,
    output d_access, d_cs, d_addr, d_bytesel, d_wr_en, d_wr_val,
    input  d_data, d_ack,
    input  m_access, m_addr, m_bytesel, m_wr_en, m_wr_val,
    output m_data, m_ack
  );

endinterface

// File: rtl/keynsham_arb_select.sv
// Combinational grant pick between the instruction and data requesters.
// Build option KEYNSHAM_MEM_ARB_RR_EN: ties go to the port that did not win
// the previous grant; otherwise the data port always wins a tie.
// Ports:
//   i_ireq / i_dreq : valid instruction / data request
//   i_last_grant    : previous winner (round-robin build only)
//   o_grant_i_c     : instruction port selected (combinational)
//   o_grant_d_c     : data port selected (combinational)
module keynsham_arb_select
  import keynsham_mem_arbiter_pkg::*;
(
  input  logic   i_ireq,
  input  logic   i_dreq,
`ifdef KEYNSHAM_MEM_ARB_RR_EN
  input  grant_e i_last_grant,
`endif
  output logic   o_grant_i_c,
  output logic   o_grant_d_c
);

  always_comb begin
    o_grant_i_c = 1'b0;
    o_grant_d_c = 1'b0;
`ifdef KEYNSHAM_MEM_ARB_RR_EN
    if (i_ireq && i_dreq) begin
      // tie: whoever lost last time goes now
      if (i_last_grant == GRANT_I) begin
        o_grant_d_c = 1'b1;
      end else begin
        o_grant_i_c = 1'b1;
      end
    end else begin
      o_grant_i_c = i_ireq;
      o_grant_d_c = i_dreq;
    end
`else
    o_grant_d_c = i_dreq;
    o_grant_i_c = i_ireq && !i_dreq;
`endif
  end

endmodule

// File: rtl/keynsham_mem_arbiter.sv
// Shares one single-ported memory between the Keynsham instruction and data
// buses. One request is granted at a time, its fields are registered onto the
// memory port, and on memory completion a one-cycle ack with read data is
// returned to the granted requester (data is 0 for writes).
// Build option KEYNSHAM_MEM_ARB_RR_EN: round-robin tie breaking with a
// last_grant flop; undefined gives fixed data-port priority.
// Ports:
//   clk : system clock, posedge
//   rst : synchronous active-high reset
//   bus : keynsham_mem_arbiter_if.slave (instruction bus, data bus, memory port)
module keynsham_mem_arbiter
  import keynsham_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  keynsham_mem_arbiter_if.slave  bus
);

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;

  state_e                r_state;
  logic                  r_m_access;
  logic [ADDR_WIDTH-1:0] r_m_addr;
  mem_ctl_t              r_m_ctl;
  logic                  r_i_ack;
  logic                  r_d_ack;
  logic [DATA_W-1:0]     r_i_data;
  logic [DATA_W-1:0]     r_d_data;
`ifdef KEYNSHAM_MEM_ARB_RR_EN
  grant_e                r_last_grant;
`endif

  assign w_i_req = bus.i_access && bus.i_cs;
  assign w_d_req = bus.d_access && bus.d_cs;

  keynsham_arb_select u_select (
    .i_ireq       (w_i_req),
    .i_dreq       (w_d_req),
`ifdef KEYNSHAM_MEM_ARB_RR_EN
    .i_last_grant (r_last_grant),
`endif
    .o_grant_i_c  (w_grant_i),
    .o_grant_d_c  (w_grant_d)
  );

  // Arbiter FSM; grants are only taken in IDLE so RESP always leaves a gap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_m_access <= 1'b0;
      r_m_addr   <= '0;
      r_m_ctl    <= '0;
      r_i_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_i_data   <= '0;
      r_d_data   <= '0;
`ifdef KEYNSHAM_MEM_ARB_RR_EN
      r_last_grant <= GRANT_I;
`endif
    end else begin
      // acks are single-cycle pulses and data is zero outside them
      r_i_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      r_i_data <= '0;
      r_d_data <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_m_addr   <= bus.d_addr;
            r_m_ctl    <= '{bytesel: bus.d_bytesel, wr_en: bus.d_wr_en,
                            wr_val: bus.d_wr_val};
            r_m_access <= 1'b1;
            r_state    <= ST_BUSY_D;
`ifdef KEYNSHAM_MEM_ARB_RR_EN
            r_last_grant <= GRANT_D;
`endif
          end else if (w_grant_i) begin
            r_m_addr   <= bus.i_addr;
            r_m_ctl    <= '{bytesel: BSEL_ALL, wr_en: 1'b0, wr_val: '0};
            r_m_access <= 1'b1;
            r_state    <= ST_BUSY_I;
`ifdef KEYNSHAM_MEM_ARB_RR_EN
            r_last_grant <= GRANT_I;
`endif
          end
        end
        ST_BUSY_I: begin
          if (bus.m_ack) begin
            r_m_access <= 1'b0;
            r_i_ack    <= 1'b1;
            r_i_data   <= bus.m_data;
            r_state    <= ST_RESP;
          end
        end
        ST_BUSY_D: begin
          if (bus.m_ack) begin
            r_m_access <= 1'b0;
            r_d_ack    <= 1'b1;
            r_d_data   <= r_m_ctl.wr_en ? '0 : bus.m_data;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          // ack pulse is visible this cycle; m_ack here is ignored
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_access  = r_m_access;
  assign bus.m_addr    = r_m_addr;
  assign bus.m_bytesel = r_m_ctl.bytesel;
  assign bus.m_wr_en   = r_m_ctl.wr_en;
  assign bus.m_wr_val  = r_m_ctl.wr_val;
  assign bus.i_ack     = r_i_ack;
  assign bus.i_data    = r_i_data;
  assign bus.d_ack     = r_d_ack;
  assign bus.d_data    = r_d_data;

endmodule

// File: tb/tb_keynsham_mem_arbiter.sv
// Self-checking bench for keynsham_mem_arbiter. A behavioural memory answers
// m_access after mem_lat cycles; expected acks are queued when requests are
// driven and popped as acks appear.
module tb_keynsham_mem_arbiter;
  import keynsham_mem_arbiter_pkg::*;

  localparam int unsigned AW = 30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keynsham_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  keynsham_mem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] mem_arr [logic [AW-1:0]];
  int          mem_lat = 1;
  bit          mem_auto = 1'b1;
  int          mem_cnt = 0;
  logic [31:0] wr_tmp;
  bit          last_d = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return 32'hC0DE0000 ^ 32'(a);
  endfunction

  // memory model: acks mem_lat cycles after it first sees m_access
  initial begin : mem_model
    bus.m_ack  = 1'b0;
    bus.m_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_auto) begin
        bus.m_ack  = 1'b0;
        bus.m_data = '0;
        if (bus.m_access === 1'b1) begin
          mem_cnt++;
          if (mem_cnt > mem_lat) begin
            bus.m_ack = 1'b1;
            mem_cnt   = 0;
            if (bus.m_wr_en) begin
              wr_tmp = mem_rd(bus.m_addr);
              for (int b = 0; b < 4; b++)
                if (bus.m_bytesel[b]) wr_tmp[8*b +: 8] = bus.m_wr_val[8*b +: 8];
              mem_arr[bus.m_addr] = wr_tmp;
              bus.m_data = 32'hFFFF_FFFF;
            end else begin
              bus.m_data = mem_rd(bus.m_addr);
            end
          end
        end else begin
          mem_cnt = 0;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // continuous protocol monitor
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        checks++;
        if ((bus.i_ack & bus.d_ack) !== 1'b0) begin
          errors++;
          $display("FAIL ack_overlap: i_ack=%b d_ack=%b, required not both", bus.i_ack, bus.d_ack);
        end
        if (bus.i_ack !== 1'b1) begin
          checks++;
          if (bus.i_data !== 32'h0) begin
            errors++;
            $display("FAIL i_data_idle: got %h, expected 0", bus.i_data);
          end
        end
        if (bus.d_ack !== 1'b1) begin
          checks++;
          if (bus.d_data !== 32'h0) begin
            errors++;
            $display("FAIL d_data_idle: got %h, expected 0", bus.d_data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // waits (bounded) for either ack; k is an absolute cycle index starting at k0
  task automatic wait_ack(input int k0, input int bound, output int k,
                          output bit got_d, output logic [31:0] data);
    k = -1;
    got_d = 1'b0;
    data = '0;
    for (int c = k0; c < k0 + bound; c++) begin
      @(negedge clk);
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
        k = c;
        got_d = (bus.d_ack === 1'b1);
        data = got_d ? bus.d_data : bus.i_data;
        return;
      end
    end
  endtask

  task automatic drop_all();
    bus.i_access = 1'b0;
    bus.i_cs     = 1'b0;
    bus.d_access = 1'b0;
    bus.d_cs     = 1'b0;
    bus.d_wr_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drop_all();
    bus.i_addr = '0; bus.d_addr = '0; bus.d_bytesel = '0; bus.d_wr_val = '0;
    repeat (3) @(negedge clk);
    checks += 9;
    if (bus.m_access !== 1'b0) begin errors++; $display("FAIL rst_m_access: got %b, expected 0", bus.m_access); end
    if (bus.m_addr !== '0) begin errors++; $display("FAIL rst_m_addr: got %h, expected 0", bus.m_addr); end
    if (bus.m_bytesel !== 4'h0) begin errors++; $display("FAIL rst_m_bytesel: got %h, expected 0", bus.m_bytesel); end
    if (bus.m_wr_en !== 1'b0) begin errors++; $display("FAIL rst_m_wr_en: got %b, expected 0", bus.m_wr_en); end
    if (bus.m_wr_val !== 32'h0) begin errors++; $display("FAIL rst_m_wr_val: got %h, expected 0", bus.m_wr_val); end
    if (bus.i_ack !== 1'b0) begin errors++; $display("FAIL rst_i_ack: got %b, expected 0", bus.i_ack); end
    if (bus.d_ack !== 1'b0) begin errors++; $display("FAIL rst_d_ack: got %b, expected 0", bus.d_ack); end
    if (bus.i_data !== 32'h0) begin errors++; $display("FAIL rst_i_data: got %h, expected 0", bus.i_data); end
    if (bus.d_data !== 32'h0) begin errors++; $display("FAIL rst_d_data: got %h, expected 0", bus.d_data); end
    rst = 1'b0;
    last_d = 1'b0;
  endtask

  task automatic test_single_fetch();
    int k; bit got_d; logic [31:0] data; exp_t e;
    mem_arr[30'h10] = 32'hdeadbeef;
    mem_lat = 1;
    @(negedge clk);
    bus.i_access = 1'b1; bus.i_cs = 1'b1; bus.i_addr = 30'h10;
    sb.push_back('{1'b0, mem_rd(30'h10)});
    @(negedge clk);
    checks += 5;
    if (bus.m_access !== 1'b1) begin errors++; $display("FAIL fetch_m_access: got %b, expected 1", bus.m_access); end
    if (bus.m_addr !== 30'h10) begin errors++; $display("FAIL fetch_m_addr: got %h, expected 10", bus.m_addr); end
    if (bus.m_bytesel !== 4'hf) begin errors++; $display("FAIL fetch_m_bytesel: got %h, expected f", bus.m_bytesel); end
    if (bus.m_wr_en !== 1'b0) begin errors++; $display("FAIL fetch_m_wr_en: got %b, expected 0", bus.m_wr_en); end
    if (bus.i_ack !== 1'b0) begin errors++; $display("FAIL fetch_early_ack: got %b, expected 0", bus.i_ack); end
    wait_ack(2, 20, k, got_d, data);
    drop_all();
    e = (sb.size() > 0) ? sb.pop_front() : '{1'b1, 32'hx};
    checks += 3;
    if (k !== 3) begin errors++; $display("FAIL fetch_latency: got %0d, expected 3", k); end
    if (got_d !== 1'b0) begin errors++; $display("FAIL fetch_port: got d=%b, expected d=0", got_d); end
    if (data !== e.data) begin errors++; $display("FAIL fetch_data: got %h, expected %h", data, e.data); end
    last_d = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus.i_ack !== 1'b0) begin errors++; $display("FAIL fetch_pulse_len: got %b, expected 0", bus.i_ack); end
    if (bus.m_access !== 1'b0) begin errors++; $display("FAIL fetch_m_drop: got %b, expected 0", bus.m_access); end
  endtask

  task automatic test_data_write();
    int k; bit got_d; logic [31:0] data; exp_t e;
    @(negedge clk);
    bus.d_access = 1'b1; bus.d_cs = 1'b1; bus.d_addr = 30'h20;
    bus.d_bytesel = 4'b0011; bus.d_wr_en = 1'b1; bus.d_wr_val = 32'h1234;
    sb.push_back('{1'b1, 32'h0});
    @(negedge clk);
    checks += 5;
    if (bus.m_access !== 1'b1) begin errors++; $display("FAIL wr_m_access: got %b, expected 1", bus.m_access); end
    if (bus.m_wr_en !== 1'b1) begin errors++; $display("FAIL wr_m_wr_en: got %b, expected 1", bus.m_wr_en); end
    if (bus.m_addr !== 30'h20) begin errors++; $display("FAIL wr_m_addr: got %h, expected 20", bus.m_addr); end
    if (bus.m_bytesel !== 4'b0011) begin errors++; $display("FAIL wr_m_bytesel: got %h, expected 3", bus.m_bytesel); end
    if (bus.m_wr_val !== 32'h1234) begin errors++; $display("FAIL wr_m_wr_val: got %h, expected 1234", bus.m_wr_val); end
    wait_ack(2, 20, k, got_d, data);
    drop_all();
    e = (sb.size() > 0) ? sb.pop_front() : '{1'b0, 32'hx};
    checks += 3;
    if (k !== 3) begin errors++; $display("FAIL wr_latency: got %0d, expected 3", k); end
    if (got_d !== e.is_d) begin errors++; $display("FAIL wr_port: got d=%b, expected d=%b", got_d, e.is_d); end
    if (data !== e.data) begin errors++; $display("FAIL wr_data: got %h, expected %h", data, e.data); end
    last_d = 1'b1;
    // read back the partially written word
    @(negedge clk);
    bus.d_access = 1'b1; bus.d_cs = 1'b1; bus.d_addr = 30'h20; bus.d_wr_en = 1'b0;
    sb.push_back('{1'b1, mem_rd(30'h20)});
    wait_ack(1, 20, k, got_d, data);
    drop_all();
    e = (sb.size() > 0) ? sb.pop_front() : '{1'b0, 32'hx};
    checks += 2;
    if (got_d !== 1'b1) begin errors++; $display("FAIL rdback_port: got d=%b, expected d=1", got_d); end
    if (data !== e.data) begin errors++; $display("FAIL rdback_data: got %h, expected %h", data, e.data); end
    last_d = 1'b1;
  endtask

  task automatic test_simultaneous();
    int k; int k1; bit got_d; logic [31:0] data; exp_t e; bit first_d;
    mem_arr[30'h40] = 32'hAAAA_0040;
    mem_arr[30'h50] = 32'hBBBB_0050;
`ifdef KEYNSHAM_MEM_ARB_RR_EN
    first_d = !last_d;
`else
    first_d = 1'b1;
`endif
    if (first_d) begin
      sb.push_back('{1'b1, mem_rd(30'h50)});
      sb.push_back('{1'b0, mem_rd(30'h40)});
    end else begin
      sb.push_back('{1'b0, mem_rd(30'h40)});
      sb.push_back('{1'b1, mem_rd(30'h50)});
    end
    @(negedge clk);
    bus.i_access = 1'b1; bus.i_cs = 1'b1; bus.i_addr = 30'h40;
    bus.d_access = 1'b1; bus.d_cs = 1'b1; bus.d_addr = 30'h50; bus.d_wr_en = 1'b0;
    k1 = 0;
    for (int n = 0; n < 2; n++) begin
      wait_ack(k1 + 1, 30, k, got_d, data);
      if (got_d) begin bus.d_access = 1'b0; bus.d_cs = 1'b0; end
      else begin bus.i_access = 1'b0; bus.i_cs = 1'b0; end
      e = (sb.size() > 0) ? sb.pop_front() : '{!got_d, 32'hx};
      checks += 3;
      if (got_d !== e.is_d) begin errors++; $display("FAIL tie_order%0d: got d=%b, expected d=%b", n, got_d, e.is_d); end
      if (data !== e.data) begin errors++; $display("FAIL tie_data%0d: got %h, expected %h", n, data, e.data); end
      if (k !== ((n == 0) ? 3 : 7)) begin errors++; $display("FAIL tie_cycle%0d: got %0d, expected %0d", n, k, (n == 0) ? 3 : 7); end
      last_d = got_d;
      k1 = (k < 0) ? k1 + 30 : k;
    end
    drop_all();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int k; int kp; bit got_d; logic [31:0] data; exp_t e; bit w;
    logic [AW-1:0] ia; logic [AW-1:0] da;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    last_d = 1'b0;
    ia = 30'h100; da = 30'h200;
    for (int g = 0; g < 6; g++) begin
`ifdef KEYNSHAM_MEM_ARB_RR_EN
      w = !last_d;
`else
      w = 1'b1;
`endif
      last_d = w;
      if (w) begin sb.push_back('{1'b1, mem_rd(da)}); da++; end
      else begin sb.push_back('{1'b0, mem_rd(ia)}); ia++; end
    end
    bus.i_access = 1'b1; bus.i_cs = 1'b1; bus.i_addr = 30'h100;
    bus.d_access = 1'b1; bus.d_cs = 1'b1; bus.d_addr = 30'h200; bus.d_wr_en = 1'b0;
    kp = 0;
    for (int g = 0; g < 6; g++) begin
      wait_ack(kp + 1, 30, k, got_d, data);
      if (got_d) bus.d_addr = bus.d_addr + AW'(1);
      else bus.i_addr = bus.i_addr + AW'(1);
      if (g == 5) drop_all();
      e = (sb.size() > 0) ? sb.pop_front() : '{!got_d, 32'hx};
      checks += 2;
      if (got_d !== e.is_d) begin errors++; $display("FAIL rr_order%0d: got d=%b, expected d=%b", g, got_d, e.is_d); end
      if (data !== e.data) begin errors++; $display("FAIL rr_data%0d: got %h, expected %h", g, data, e.data); end
      if (k < 0) begin sb.delete(); break; end
      kp = k;
    end
    drop_all();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_slow_mem();
    int k; int extra; bit got_d; logic [31:0] data; exp_t e;
    mem_lat = 5;
    @(negedge clk);
    bus.i_access = 1'b1; bus.i_cs = 1'b1; bus.i_addr = 30'h33;
    sb.push_back('{1'b0, mem_rd(30'h33)});
    k = -1; data = '0;
    for (int c = 1; c < 30; c++) begin
      @(negedge clk);
      if (bus.i_ack === 1'b1) begin k = c; data = bus.i_data; break; end
      checks += 3;
      if (bus.m_access !== 1'b1) begin errors++; $display("FAIL slow_m_access c%0d: got %b, expected 1", c, bus.m_access); end
      if (bus.m_addr !== 30'h33) begin errors++; $display("FAIL slow_m_addr c%0d: got %h, expected 33", c, bus.m_addr); end
      if (bus.m_bytesel !== 4'hf || bus.m_wr_en !== 1'b0) begin
        errors++; $display("FAIL slow_m_ctl c%0d: got bsel=%h wr=%b, expected f/0", c, bus.m_bytesel, bus.m_wr_en);
      end
    end
    drop_all();
    e = (sb.size() > 0) ? sb.pop_front() : '{1'b1, 32'hx};
    checks += 2;
    if (k !== 7) begin errors++; $display("FAIL slow_latency: got %0d, expected 7", k); end
    if (data !== e.data) begin errors++; $display("FAIL slow_data: got %h, expected %h", data, e.data); end
    last_d = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL slow_extra_ack: got %0d, expected 0", extra); end
    // spurious m_ack while idle
    mem_auto = 1'b0;
    @(negedge clk); bus.m_ack = 1'b1; bus.m_data = 32'h5555_5555;
    @(negedge clk); bus.m_ack = 1'b0; bus.m_data = '0;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1 || bus.m_access === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL spurious_m_ack: got %0d responses, expected 0", extra); end
    mem_auto = 1'b1;
    mem_lat = 1;
  endtask

  task automatic test_reset_mid();
    int k; int extra; bit got_d; logic [31:0] data; exp_t e;
    mem_auto = 1'b0;
    @(negedge clk);
    bus.d_access = 1'b1; bus.d_cs = 1'b1; bus.d_addr = 30'h60; bus.d_wr_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.m_access !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b, expected 1", bus.m_access); end
    rst = 1'b1;
    drop_all();
    @(negedge clk);
    checks += 2;
    if (bus.m_access !== 1'b0) begin errors++; $display("FAIL rmid_m_access: got %b, expected 0", bus.m_access); end
    if (bus.d_ack !== 1'b0) begin errors++; $display("FAIL rmid_d_ack: got %b, expected 0", bus.d_ack); end
    rst = 1'b0;
    last_d = 1'b0;
    @(negedge clk); bus.m_ack = 1'b1; bus.m_data = 32'h7777_7777;
    @(negedge clk); bus.m_ack = 1'b0; bus.m_data = '0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL rmid_late_ack: got %0d acks, expected 0", extra); end
    mem_auto = 1'b1;
    @(negedge clk);
    bus.i_access = 1'b1; bus.i_cs = 1'b1; bus.i_addr = 30'h70;
    sb.push_back('{1'b0, mem_rd(30'h70)});
    wait_ack(1, 20, k, got_d, data);
    drop_all();
    e = (sb.size() > 0) ? sb.pop_front() : '{1'b1, 32'hx};
    checks += 3;
    if (k !== 3) begin errors++; $display("FAIL rmid_next_latency: got %0d, expected 3", k); end
    if (got_d !== e.is_d) begin errors++; $display("FAIL rmid_next_port: got d=%b, expected d=%b", got_d, e.is_d); end
    if (data !== e.data) begin errors++; $display("FAIL rmid_next_data: got %h, expected %h", data, e.data); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_write();
    test_simultaneous();
    test_round_robin();
    test_slow_mem();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_leftover: got %0d entries, expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
